// File: rtl/mips16_ctrl_defs.sv
// -----------------------------------------------------------------------------
// mips16_ctrl_defs
// Shared definitions for the mips_16 pipeline control blocks:
//   - stall_state_t : FSM state encoding of the stall controller
//   - NOP_INSTR     : instruction word loaded by the flush/bubble muxes
//   - stage_ctrl_t  : bundle of per-stage enable/flush/bubble controls
//   - decode_ctrl() : priority decode halt > branch > hazard > normal
// -----------------------------------------------------------------------------
package mips16_ctrl_defs;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        HALT  = 2'd2
    } stall_state_t;

    // All-zero word: dest reg 0, no write-back, no memory access.
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_bubble;
        logic pipe_en;
    } stage_ctrl_t;

    // Zero-latency control decode; a taken branch squashes the decoded
    // instruction, so a concurrent hazard request is irrelevant.
    function automatic stage_ctrl_t decode_ctrl(
        input logic debug_halt,
        input logic branch_taken,
        input logic pipeline_stall_n
    );
        stage_ctrl_t c;
        if (debug_halt) begin
            c = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
                  id_ex_bubble: 1'b0, pipe_en: 1'b0};
        end else if (branch_taken) begin
            c = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1,
                  id_ex_bubble: 1'b1, pipe_en: 1'b1};
        end else if (!pipeline_stall_n) begin
            c = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
                  id_ex_bubble: 1'b1, pipe_en: 1'b1};
        end else begin
            c = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
                  id_ex_bubble: 1'b0, pipe_en: 1'b1};
        end
        return c;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear (clear wins over increment).
// Ports:
//   clk   in  rising-edge clock
//   rst   in  asynchronous active-high reset
//   inc   in  count up by one this cycle (held at all-ones once reached)
//   clr   in  synchronous clear to zero
//   count out W-bit registered count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;
    logic [W-1:0] count_nxt_s;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        count_nxt_s = count_r;
        if (clr) begin
            count_nxt_s = {W{1'b0}};
        end else if (inc && !(&count_r)) begin
            count_nxt_s = count_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else begin
            count_r <= count_nxt_s;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_stall_ctrl
// Turns the hazard unit's stall request, the EX branch-taken squash and the
// debug halt into per-stage controls for the mips_16 5-stage pipeline, and
// keeps stall statistics plus a stuck-stall watchdog.
// Ports:
//   clk, rst          clock / asynchronous active-high reset
//   pipeline_stall_n  0 = RAW hazard, hold fetch/decode this cycle
//   branch_taken      squash IF/ID and ID/EX this cycle
//   debug_halt        freeze the whole pipeline
//   clear_stats       synchronous clear of statistics and timeout
//   pc_en, if_id_en, if_id_flush, id_ex_bubble, pipe_en
//                     combinational stage controls (same-cycle response)
//   stall_active      previous cycle was a hazard stall
//   stall_cycles      saturating count of stall cycles
//   stall_events      saturating count of stall runs started
//   max_run           longest consecutive stall run
//   stall_timeout     sticky: a run reached STALL_LIMIT cycles
// -----------------------------------------------------------------------------
module pipeline_stall_ctrl
    import mips16_ctrl_defs::*;
#(
    parameter int CNT_W       = 16,
    parameter int RUN_W       = 8,
    parameter int STALL_LIMIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pipeline_stall_n,
    input  logic             branch_taken,
    input  logic             debug_halt,
    input  logic             clear_stats,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             pipe_en,
    output logic             stall_active,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] stall_events,
    output logic [RUN_W-1:0] max_run,
    output logic             stall_timeout
);

    localparam logic [RUN_W:0] LIMIT_W = (RUN_W+1)'(STALL_LIMIT);

    stage_ctrl_t      ctrl_s;
    logic             stall_applied_s;
    stall_state_t     state_r;
    stall_state_t     next_state_s;
    logic [RUN_W-1:0] run_len_r;
    logic [RUN_W:0]   run_len_plus1_s;
    logic [RUN_W-1:0] run_len_inc_s;
    logic             event_inc_s;
    logic             timeout_hit_s;
    logic             max_grow_s;
    logic [RUN_W-1:0] max_run_r;
    logic             stall_active_r;
    logic             stall_timeout_r;

    // Stage controls and the "hazard stall actually applied" qualifier.
    always_comb begin
        ctrl_s          = decode_ctrl(debug_halt, branch_taken, pipeline_stall_n);
        stall_applied_s = !debug_halt && !branch_taken && !pipeline_stall_n;
    end

    assign pc_en        = ctrl_s.pc_en;
    assign if_id_en     = ctrl_s.if_id_en;
    assign if_id_flush  = ctrl_s.if_id_flush;
    assign id_ex_bubble = ctrl_s.id_ex_bubble;
    assign pipe_en      = ctrl_s.pipe_en;

    // Next-state logic of the RUN/STALL/HALT controller.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            RUN: begin
                if (debug_halt) begin
                    next_state_s = HALT;
                end else if (stall_applied_s) begin
                    next_state_s = STALL;
                end else begin
                    next_state_s = RUN;
                end
            end
            STALL: begin
                if (debug_halt) begin
                    next_state_s = HALT;
                end else if (branch_taken || pipeline_stall_n) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = STALL;
                end
            end
            HALT: begin
                if (debug_halt) begin
                    next_state_s = HALT;
                end else if (stall_applied_s) begin
                    next_state_s = STALL;
                end else begin
                    next_state_s = RUN;
                end
            end
            default: begin
                next_state_s = RUN;
            end
        endcase
    end

    // Run-length arithmetic. A run whose length is still zero is a fresh
    // run; a run resumed after a halt keeps its length and is not re-counted.
    always_comb begin
        run_len_plus1_s = {1'b0, run_len_r} + {{RUN_W{1'b0}}, 1'b1};
        if (&run_len_r) begin
            run_len_inc_s = run_len_r;
        end else begin
            run_len_inc_s = run_len_plus1_s[RUN_W-1:0];
        end
        event_inc_s   = stall_applied_s && (run_len_r == {RUN_W{1'b0}});
        timeout_hit_s = stall_applied_s && (run_len_plus1_s == LIMIT_W);
        max_grow_s    = stall_applied_s && (run_len_plus1_s > {1'b0, max_run_r});
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= RUN;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Current run length: cleared whenever the pipeline returns to RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_len_r <= {RUN_W{1'b0}};
        end else if (next_state_s == RUN) begin
            run_len_r <= {RUN_W{1'b0}};
        end else if (stall_applied_s) begin
            run_len_r <= run_len_inc_s;
        end else begin
            run_len_r <= run_len_r;
        end
    end

    // Longest run and sticky watchdog; clear_stats wins over an update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_run_r       <= {RUN_W{1'b0}};
            stall_timeout_r <= 1'b0;
        end else if (clear_stats) begin
            max_run_r       <= {RUN_W{1'b0}};
            stall_timeout_r <= 1'b0;
        end else begin
            max_run_r       <= max_grow_s ? run_len_inc_s : max_run_r;
            stall_timeout_r <= stall_timeout_r || timeout_hit_s;
        end
    end

    // Registered copy of "stall applied this cycle".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_active_r <= 1'b0;
        end else begin
            stall_active_r <= stall_applied_s;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cycles (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_applied_s),
        .clr   (clear_stats),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_stall_events (
        .clk   (clk),
        .rst   (rst),
        .inc   (event_inc_s),
        .clr   (clear_stats),
        .count (stall_events)
    );

    assign stall_active  = stall_active_r;
    assign max_run       = max_run_r;
    assign stall_timeout = stall_timeout_r;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: control truth table, directed
// multi-cycle sequences and randomized traffic against a statistics model.
module tb_pipeline_stall_ctrl;

    localparam int CNT_W       = 16;
    localparam int RUN_W       = 8;
    localparam int STALL_LIMIT = 8;
    localparam int RUN_MAX     = (1 << RUN_W) - 1;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             pipeline_stall_n;
    logic             branch_taken;
    logic             debug_halt;
    logic             clear_stats;
    logic             pc_en, if_id_en, if_id_flush, id_ex_bubble, pipe_en;
    logic             stall_active;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] stall_events;
    logic [RUN_W-1:0] max_run;
    logic             stall_timeout;

    pipeline_stall_ctrl #(
        .CNT_W(CNT_W), .RUN_W(RUN_W), .STALL_LIMIT(STALL_LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .pipeline_stall_n(pipeline_stall_n), .branch_taken(branch_taken),
        .debug_halt(debug_halt), .clear_stats(clear_stats),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .pipe_en(pipe_en),
        .stall_active(stall_active), .stall_cycles(stall_cycles),
        .stall_events(stall_events), .max_run(max_run),
        .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: statistics as plain integers.
    int m_cycles, m_events, m_max, m_run, m_timeout, m_active;

    typedef struct {
        logic       h;
        logic       b;
        logic       sn;
        logic [4:0] exp;   // {pc_en, if_id_en, if_id_flush, id_ex_bubble, pipe_en}
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [4:0] exp_ctrl(input logic h, input logic b, input logic sn);
        if (h)        return 5'b00000;
        else if (b)   return 5'b11111;
        else if (!sn) return 5'b00011;
        else          return 5'b11001;
    endfunction

    function automatic logic [4:0] ctrl_vec();
        return {pc_en, if_id_en, if_id_flush, id_ex_bubble, pipe_en};
    endfunction

    task automatic model_reset();
        m_cycles = 0; m_events = 0; m_max = 0; m_run = 0; m_timeout = 0; m_active = 0;
    endtask

    // One clock of the statistics rules, evaluated at the edge.
    task automatic model_step(input logic h, input logic b, input logic sn, input logic clr);
        bit applied;
        applied = !h && !b && !sn;
        if (applied) begin
            if (m_run == 0) m_events = (m_events < CNT_MAX) ? m_events + 1 : m_events;
            if (m_run + 1 == STALL_LIMIT) m_timeout = 1;
            m_run    = (m_run < RUN_MAX) ? m_run + 1 : m_run;
            m_max    = (m_run > m_max) ? m_run : m_max;
            m_cycles = (m_cycles < CNT_MAX) ? m_cycles + 1 : m_cycles;
        end else if (!h) begin
            m_run = 0;            // pipeline back to normal running
        end
        if (clr) begin
            m_cycles = 0; m_events = 0; m_max = 0; m_timeout = 0;
        end
        m_active = applied ? 1 : 0;
    endtask

    task automatic check_stats(input string tag);
        chk({tag, ".stall_active"},  32'(stall_active),  32'(m_active));
        chk({tag, ".stall_cycles"},  32'(stall_cycles),  32'(m_cycles));
        chk({tag, ".stall_events"},  32'(stall_events),  32'(m_events));
        chk({tag, ".max_run"},       32'(max_run),       32'(m_max));
        chk({tag, ".stall_timeout"}, 32'(stall_timeout), 32'(m_timeout));
    endtask

    // Drive one cycle, check controls before the edge and stats after it.
    task automatic cycle(input logic h, input logic b, input logic sn, input logic clr);
        @(negedge clk);
        debug_halt = h; branch_taken = b; pipeline_stall_n = sn; clear_stats = clr;
        #1;
        chk("ctrl", 32'(ctrl_vec()), 32'(exp_ctrl(h, b, sn)));
        model_step(h, b, sn, clr);
        @(posedge clk);
        #1;
        check_stats("cyc");
    endtask

    task automatic do_reset();
        @(negedge clk);
        debug_halt = 1'b0; branch_taken = 1'b0; pipeline_stall_n = 1'b1; clear_stats = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        #1 check_stats("rst");
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        logic h, b, sn, clr;

        tbl[0] = '{h: 1'b0, b: 1'b0, sn: 1'b1, exp: 5'b11001};
        tbl[1] = '{h: 1'b0, b: 1'b0, sn: 1'b0, exp: 5'b00011};
        tbl[2] = '{h: 1'b0, b: 1'b1, sn: 1'b1, exp: 5'b11111};
        tbl[3] = '{h: 1'b0, b: 1'b1, sn: 1'b0, exp: 5'b11111};
        tbl[4] = '{h: 1'b1, b: 1'b0, sn: 1'b1, exp: 5'b00000};
        tbl[5] = '{h: 1'b1, b: 1'b0, sn: 1'b0, exp: 5'b00000};
        tbl[6] = '{h: 1'b1, b: 1'b1, sn: 1'b1, exp: 5'b00000};
        tbl[7] = '{h: 1'b1, b: 1'b1, sn: 1'b0, exp: 5'b00000};

        // Reset state.
        rst = 1'b1; debug_halt = 1'b0; branch_taken = 1'b0;
        pipeline_stall_n = 1'b1; clear_stats = 1'b0;
        model_reset();
        #3;
        chk("reset.ctrl", 32'(ctrl_vec()), 32'(5'b11001));
        check_stats("reset");
        #9 rst = 1'b0;

        // Control truth table (purely combinational).
        for (int i = 0; i < 8; i++) begin
            debug_halt = tbl[i].h; branch_taken = tbl[i].b; pipeline_stall_n = tbl[i].sn;
            #1;
            chk($sformatf("table[%0d]", i), 32'(ctrl_vec()), 32'(tbl[i].exp));
        end
        do_reset();

        // Three-cycle stall.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            chk("stall3.active", 32'(stall_active), 32'd1);
        end
        chk("stall3.cycles", 32'(stall_cycles), 32'd3);
        chk("stall3.events", 32'(stall_events), 32'd1);
        chk("stall3.max_run", 32'(max_run), 32'd3);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("stall3.active_end", 32'(stall_active), 32'd0);
        do_reset();

        // Branch overrides a same-cycle stall; a following stall is a new run.
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        chk("branch.cycles", 32'(stall_cycles), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("branch.events_after", 32'(stall_events), 32'd1);
        do_reset();

        // Watchdog: fires on the edge ending the STALL_LIMIT-th stall cycle.
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            if (i == STALL_LIMIT - 1) chk("timeout.before", 32'(stall_timeout), 32'd0);
            if (i == STALL_LIMIT)     chk("timeout.at",     32'(stall_timeout), 32'd1);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("timeout.sticky", 32'(stall_timeout), 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        chk("clear.timeout", 32'(stall_timeout), 32'd0);
        chk("clear.max_run", 32'(max_run), 32'd0);
        chk("clear.cycles", 32'(stall_cycles), 32'd0);
        chk("clear.events", 32'(stall_events), 32'd0);
        do_reset();

        // Stall interrupted by halt, then resumed.
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("halt.cycles_frozen", 32'(stall_cycles), 32'd2);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("halt.events", 32'(stall_events), 32'd1);
        chk("halt.max_run", 32'(max_run), 32'd3);
        chk("halt.cycles", 32'(stall_cycles), 32'd3);

        // Asynchronous reset in the middle of a stall.
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("arst.active", 32'(stall_active), 32'd0);
        chk("arst.cycles", 32'(stall_cycles), 32'd0);
        chk("arst.events", 32'(stall_events), 32'd0);
        chk("arst.max_run", 32'(max_run), 32'd0);
        pipeline_stall_n = 1'b1;
        #1;
        chk("arst.ctrl", 32'(ctrl_vec()), 32'(5'b11001));
        @(negedge clk);
        #2 rst = 1'b0;

        // Randomized traffic; the hazard line is sticky so long runs occur.
        sn = 1'b1;
        for (int i = 0; i < 500; i++) begin
            h   = ($urandom_range(7) == 0);
            b   = ($urandom_range(5) == 0);
            clr = ($urandom_range(39) == 0);
            if ($urandom_range(4) == 0) sn = ~sn;
            cycle(h, b, sn, clr);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
